l1_cache_nway: RTL and testbench

// - Parametrised N-way set-associative, write-back, write-allocate L1 cache; drop-in successor to the 1/2-way L1.
// - Sits between core fetch/LSU (proc_gen_bus_if) and the memory arbiter (mem_gen_bus_if); usable as icache or dcache.
// - Adds: ASSOC 1..8 with true-LRU replacement, byte-enable writes, non-cacheable pass-through, and working flush/clear.

---
 rtl/l1_cache_nway.sv | 387 ++++++++++++++++++++++++++++++++++++++
 tb/tb_l1_cache_nway.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_nway.sv
// l1_cache_nway
//   N-way set-associative, write-back, write-allocate L1 cache with true-LRU
//   replacement, byte-enable writes, a non-cacheable pass-through window and
//   flush/clear engines. Usable as either icache or dcache.
//
// Optional feature: define L1_NWAY_PERF_CNT_EN to add the hit_count/miss_count
// saturating performance counters (and their output ports).
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   clear / clear_done   write back dirty frames, invalidate all; 1-cycle done pulse
//   flush / flush_done   write back dirty frames, keep valid; 1-cycle done pulse
//   mem_*                master side towards the memory arbiter
//                        (addr/wdata/ren/wen/byte_en out, rdata/busy in)
//   proc_*               slave side towards fetch/LSU
//                        (addr/wdata/ren/wen/byte_en in, rdata/busy out)
//   hit_count/miss_count 32-bit counters, only with L1_NWAY_PERF_CNT_EN
module l1_cache_nway #(
    parameter int unsigned CACHE_SIZE          = 1024,
    parameter int unsigned BLOCK_SIZE          = 2,
    parameter int unsigned ASSOC               = 2,
    parameter logic [31:0] NONCACHE_START_ADDR = 32'h8000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        clear,
    input  logic        flush,
    output logic        clear_done,
    output logic        flush_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    input  logic [31:0] proc_addr,
    input  logic [31:0] proc_wdata,
    input  logic        proc_ren,
    input  logic        proc_wen,
    input  logic [3:0]  proc_byte_en,
    output logic [31:0] proc_rdata,
    output logic        proc_busy
`ifdef L1_NWAY_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned N_SETS    = CACHE_SIZE / (4 * BLOCK_SIZE * ASSOC);
    localparam int unsigned WORD_BITS = $clog2(BLOCK_SIZE);
    localparam int unsigned SET_BITS  = $clog2(N_SETS);
    localparam int unsigned TAG_BITS  = 32 - SET_BITS - WORD_BITS - 2;
    // Counter widths never drop to zero so degenerate configs still elaborate.
    localparam int unsigned WC_W = (BLOCK_SIZE > 1) ? WORD_BITS : 1;
    localparam int unsigned SC_W = (N_SETS > 1) ? SET_BITS : 1;
    localparam int unsigned WY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    typedef enum logic [2:0] {IDLE, WB, FETCH, PASS, FL_SCAN, FL_WB, FL_DONE} state_t;

    function automatic logic [31:0] blk_addr(input logic [TAG_BITS-1:0] t,
                                             input logic [SC_W-1:0] s,
                                             input logic [WC_W-1:0] w);
        blk_addr = (32'(t) << (SET_BITS + WORD_BITS + 2)) |
                   (32'(s) << (WORD_BITS + 2)) | (32'(w) << 2);
    endfunction

    // ---------------- state ----------------
    state_t              state_q, state_d;
    logic [WC_W-1:0]     word_q, word_d;
    logic [SC_W-1:0]     set_q, set_d;
    logic [WY_W-1:0]     way_q, way_d;
    logic [WY_W-1:0]     victim_q, victim_d;
    logic                op_clear_q, op_clear_d;

    logic [N_SETS-1:0][ASSOC-1:0] valid_q, valid_d;
    logic [N_SETS-1:0][ASSOC-1:0] dirty_q, dirty_d;
    logic [TAG_BITS-1:0]          tag_q [N_SETS][ASSOC];
    logic [TAG_BITS-1:0]          tag_d [N_SETS][ASSOC];
    logic [WY_W-1:0]              age_q [N_SETS][ASSOC];
    logic [WY_W-1:0]              age_d [N_SETS][ASSOC];
    logic [31:0]                  data_q [N_SETS][ASSOC][BLOCK_SIZE];

    // Single data-array write port shared by hit writes and fills.
    logic                dw_en;
    logic [SC_W-1:0]     dw_set;
    logic [WY_W-1:0]     dw_way;
    logic [WC_W-1:0]     dw_word;
    logic [31:0]         dw_data;
    logic [3:0]          dw_be;
    logic                lru_en;
    logic [SC_W-1:0]     lru_set;
    logic [WY_W-1:0]     lru_way;

    // ---------------- request decode ----------------
    logic [TAG_BITS-1:0] req_tag;
    logic [SC_W-1:0]     req_set;
    logic [WC_W-1:0]     req_word;
    logic                req, uncached, tag_hit, idle_hit, found_inv;
    logic [WY_W-1:0]     hit_way, miss_way;
    logic                fl_active, last_word, last_frame;
    logic [SC_W-1:0]     cur_set;
    logic [WY_W-1:0]     cur_way;
    logic                unused_addr_bits;

    assign req_tag  = proc_addr[31 -: TAG_BITS];
    assign req_set  = SC_W'((proc_addr >> (WORD_BITS + 2)) & (N_SETS - 1));
    assign req_word = WC_W'((proc_addr >> 2) & (BLOCK_SIZE - 1));
    assign unused_addr_bits = &{1'b0, proc_addr[1:0]};
    assign req      = proc_ren | proc_wen;
    assign uncached = proc_addr >= NONCACHE_START_ADDR;
    // clear/flush take the IDLE cycle, so a coincident request is not served.
    assign idle_hit = (state_q == IDLE) && !clear && !flush && req && !uncached && tag_hit;

    always_comb begin
        tag_hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                tag_hit = 1'b1;
                hit_way = WY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest way.
    always_comb begin
        found_inv = 1'b0;
        miss_way  = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                found_inv = 1'b1;
                miss_way  = WY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (age_q[req_set][w] == WY_W'(ASSOC - 1)) miss_way = WY_W'(w);
            end
        end
    end

    // Write-back source frame: scan position during flush/clear, victim otherwise.
    assign fl_active  = (state_q == FL_SCAN) || (state_q == FL_WB);
    assign cur_set    = fl_active ? set_q : req_set;
    assign cur_way    = fl_active ? way_q : victim_q;
    assign last_word  = word_q == WC_W'(BLOCK_SIZE - 1);
    assign last_frame = (set_q == SC_W'(N_SETS - 1)) && (way_q == WY_W'(ASSOC - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clear || flush)           state_d = FL_SCAN;
                else if (req && uncached)     state_d = PASS;
                else if (req && !tag_hit)     state_d = dirty_q[req_set][miss_way] ? WB : FETCH;
            end
            WB:      if (!mem_busy && last_word) state_d = FETCH;
            FETCH:   if (!mem_busy && last_word) state_d = IDLE;
            PASS:    if (!mem_busy)              state_d = IDLE;
            FL_SCAN: begin
                if (dirty_q[set_q][way_q]) state_d = FL_WB;
                else if (last_frame)       state_d = FL_DONE;
            end
            FL_WB:   if (!mem_busy && last_word) state_d = FL_SCAN;
            FL_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_byte_en = '0;
        proc_busy   = 1'b1;
        proc_rdata  = '0;
        clear_done  = 1'b0;
        flush_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (idle_hit) begin
                    proc_busy  = 1'b0;
                    proc_rdata = data_q[req_set][hit_way][req_word];
                end
            end
            WB, FL_WB: begin
                mem_wen     = 1'b1;
                mem_addr    = blk_addr(tag_q[cur_set][cur_way], cur_set, word_q);
                mem_wdata   = data_q[cur_set][cur_way][word_q];
                mem_byte_en = 4'hF;
            end
            FETCH: begin
                mem_ren     = 1'b1;
                mem_addr    = blk_addr(req_tag, req_set, word_q);
                mem_byte_en = 4'hF;
            end
            PASS: begin
                mem_addr    = proc_addr;
                mem_wdata   = proc_wdata;
                mem_ren     = proc_ren;
                mem_wen     = proc_wen & ~proc_ren;
                mem_byte_en = proc_byte_en;
                proc_busy   = mem_busy;
                proc_rdata  = mem_rdata;
            end
            FL_DONE: begin
                clear_done = op_clear_q;
                flush_done = !op_clear_q;
            end
            default: ;
        endcase
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        word_d     = word_q;
        set_d      = set_q;
        way_d      = way_q;
        victim_d   = victim_q;
        op_clear_d = op_clear_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        age_d      = age_q;
        dw_en      = 1'b0;
        dw_set     = req_set;
        dw_way     = hit_way;
        dw_word    = req_word;
        dw_data    = proc_wdata;
        dw_be      = proc_byte_en;
        lru_en     = 1'b0;
        lru_set    = req_set;
        lru_way    = hit_way;
        unique case (state_q)
            IDLE: begin
                if (clear || flush) begin
                    op_clear_d = clear;
                    set_d      = '0;
                    way_d      = '0;
                    word_d     = '0;
                end else if (idle_hit) begin
                    lru_en = 1'b1;
                    if (proc_wen) begin
                        dw_en                    = 1'b1;
                        dirty_d[req_set][hit_way] = 1'b1;
                    end
                end else if (req && !uncached) begin
                    victim_d = miss_way;
                    word_d   = '0;
                end
            end
            WB, FL_WB: begin
                if (!mem_busy) begin
                    if (last_word) begin
                        word_d                    = '0;
                        dirty_d[cur_set][cur_way] = 1'b0;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            FETCH: begin
                if (!mem_busy) begin
                    dw_en   = 1'b1;
                    dw_way  = victim_q;
                    dw_word = word_q;
                    dw_data = mem_rdata;
                    dw_be   = 4'hF;
                    if (last_word) begin
                        word_d                     = '0;
                        valid_d[req_set][victim_q] = 1'b1;
                        dirty_d[req_set][victim_q] = 1'b0;
                        tag_d[req_set][victim_q]   = req_tag;
                        lru_en                     = 1'b1;
                        lru_way                    = victim_q;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            FL_SCAN: begin
                // A dirty frame leaves the position untouched; it is re-scanned
                // (now clean) after its write-back.
                if (!dirty_q[set_q][way_q]) begin
                    if (last_frame) begin
                        if (op_clear_q) begin
                            valid_d = '0;
                            for (int s = 0; s < N_SETS; s++)
                                for (int w = 0; w < ASSOC; w++)
                                    age_d[s][w] = WY_W'(w);
                        end
                    end else if (way_q == WY_W'(ASSOC - 1)) begin
                        way_d = '0;
                        set_d = set_q + 1'b1;
                    end else begin
                        way_d = way_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // True LRU: accessed way -> 0, younger ways age by one.
        if (lru_en) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (WY_W'(w) == lru_way)
                    age_d[lru_set][w] = '0;
                else if (age_q[lru_set][w] < age_q[lru_set][lru_way])
                    age_d[lru_set][w] = age_q[lru_set][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            word_q     <= '0;
            set_q      <= '0;
            way_q      <= '0;
            victim_q   <= '0;
            op_clear_q <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    tag_q[s][w] <= '0;
                    age_q[s][w] <= WY_W'(w);
                end
            end
        end else begin
            word_q     <= word_d;
            set_q      <= set_d;
            way_q      <= way_d;
            victim_q   <= victim_d;
            op_clear_q <= op_clear_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            tag_q      <= tag_d;
            age_q      <= age_d;
        end
    end

    // Data payload needs no reset: valid bits gate every use of it.
    always_ff @(posedge CLK) begin
        if (dw_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dw_be[b]) data_q[dw_set][dw_way][dw_word][8*b +: 8] <= dw_data[8*b +: 8];
            end
        end
    end

`ifdef L1_NWAY_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (idle_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
        if ((state_q == IDLE) && ((state_d == WB) || (state_d == FETCH)) && (miss_cnt_q != '1))
            miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_cache_nway.sv
// Directed bench for l1_cache_nway (CACHE_SIZE=1024, BLOCK_SIZE=2, ASSOC=2:
// 64 sets, set = addr[8:3], tag = addr[31:9]). The memory model returns a
// fixed pattern per address and logs every completed transfer.
module tb_l1_cache_nway;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        clear = 1'b0, flush = 1'b0;
    logic        clear_done, flush_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen, mem_busy;
    logic [3:0]  mem_byte_en;
    logic [31:0] proc_addr = '0, proc_wdata = '0, proc_rdata;
    logic        proc_ren = 1'b0, proc_wen = 1'b0, proc_busy;
    logic [3:0]  proc_byte_en = 4'hF;
`ifdef L1_NWAY_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    l1_cache_nway dut (
        .CLK(CLK), .nRST(nRST), .clear(clear), .flush(flush),
        .clear_done(clear_done), .flush_done(flush_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_ren(proc_ren), .proc_wen(proc_wen),
        .proc_byte_en(proc_byte_en), .proc_rdata(proc_rdata), .proc_busy(proc_busy)
`ifdef L1_NWAY_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // ---------------- memory model ----------------
    int lat = 1;
    int wcnt = 0;
    int both_viol = 0;
    logic [64:0] ev_q [$];   // {is_write, addr, wdata}

    function automatic logic [31:0] mem_pat(input logic [31:0] a);
        mem_pat = (a == 32'h104) ? 32'h1122_3344 : (a ^ 32'h5A00_0000);
    endfunction

    assign mem_rdata = mem_pat(mem_addr);
    assign mem_busy  = (mem_ren || mem_wen) ? (wcnt < lat) : 1'b1;

    always @(posedge CLK) begin
        if (mem_ren && mem_wen) both_viol <= both_viol + 1;
        if (mem_ren || mem_wen) begin
            if (!mem_busy) begin
                wcnt <= 0;
                ev_q.push_back({mem_wen, mem_addr, mem_wen ? mem_wdata : 32'h0});
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One processor access; returns data and the number of busy cycles seen.
    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output int bc);
        bc = 0;
        rd = '0;
        proc_addr = a; proc_wen = wr; proc_ren = !wr; proc_wdata = wd; proc_byte_en = be;
        for (int k = 0; k < 500; k++) begin
            @(negedge CLK);
            if (!proc_busy) begin
                rd = proc_rdata;
                break;
            end
            bc++;
        end
        @(posedge CLK); #1;
        proc_ren = 1'b0; proc_wen = 1'b0;
        if (bc >= 500) begin
            checks++; errors++;
            $display("FAIL access_timeout addr=%h busy never dropped", a);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (proc_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", proc_busy); end
        checks++; if (proc_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", proc_rdata); end
        checks++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL rst_ren_wen got=%b%b exp=00", mem_ren, mem_wen); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0 || mem_byte_en !== 4'h0) begin errors++; $display("FAIL rst_wdata_be got=%h/%h exp=0/0", mem_wdata, mem_byte_en); end
        checks++; if (clear_done !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b%b exp=00", clear_done, flush_done); end
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic test_read_miss();
        logic [31:0] rd; int bc;
        lat = 1; ev_q.delete();
        access(32'h100, 1'b0, 32'h0, 4'hF, rd, bc);
        // IDLE miss cycle + 2 words * (1 busy + 1 done)
        checks++; if (bc !== 5) begin errors++; $display("FAIL read_miss_busy got=%0d exp=5", bc); end
        checks++; if (rd !== 32'h5A00_0100) begin errors++; $display("FAIL read_miss_data got=%h exp=5a000100", rd); end
        checks++; if (ev_q.size() !== 2) begin errors++; $display("FAIL read_miss_nreq got=%0d exp=2", ev_q.size()); end
        else begin
            checks++; if (ev_q[0] !== {1'b0, 32'h100, 32'h0} || ev_q[1] !== {1'b0, 32'h104, 32'h0}) begin
                errors++; $display("FAIL read_miss_addrs got=%h,%h exp=R100,R104", ev_q[0], ev_q[1]); end
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int bc;
        ev_q.delete();
        access(32'h104, 1'b1, 32'hAABB_CCDD, 4'b0011, rd, bc);
        checks++; if (bc !== 0) begin errors++; $display("FAIL wr_hit_busy got=%0d exp=0", bc); end
        access(32'h104, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 0 || rd !== 32'h1122_CCDD) begin errors++; $display("FAIL wr_merge got=%h/%0d exp=1122ccdd/0", rd, bc); end
        checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL wr_hit_memtraffic got=%0d exp=0", ev_q.size()); end
    endtask

    task automatic test_evict();
        logic [31:0] rd; int bc;
        lat = 1;
        // 0x300 fills way1 (clean fetch), then the write hit makes it dirty
        access(32'h300, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, bc);
        checks++; if (bc !== 5) begin errors++; $display("FAIL evict_wr_alloc_busy got=%0d exp=5", bc); end
        access(32'h100, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 0 || rd !== 32'h5A00_0100) begin errors++; $display("FAIL evict_touch got=%h/%0d exp=5a000100/0", rd, bc); end
        ev_q.delete();
        access(32'h500, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 9) begin errors++; $display("FAIL evict_busy got=%0d exp=9", bc); end
        checks++; if (rd !== 32'h5A00_0500) begin errors++; $display("FAIL evict_data got=%h exp=5a000500", rd); end
        checks++; if (ev_q.size() !== 4) begin errors++; $display("FAIL evict_nreq got=%0d exp=4", ev_q.size()); end
        else begin
            checks++; if (ev_q[0] !== {1'b1, 32'h300, 32'hDEAD_BEEF} || ev_q[1] !== {1'b1, 32'h304, 32'h5A00_0304})
                begin errors++; $display("FAIL evict_wb got=%h,%h exp=W300 deadbeef,W304 5a000304", ev_q[0], ev_q[1]); end
            checks++; if (ev_q[2] !== {1'b0, 32'h500, 32'h0} || ev_q[3] !== {1'b0, 32'h504, 32'h0})
                begin errors++; $display("FAIL evict_fetch got=%h,%h exp=R500,R504", ev_q[2], ev_q[3]); end
        end
        access(32'h100, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 0) begin errors++; $display("FAIL evict_mru_kept got=%0d exp=0", bc); end
    endtask

    task automatic test_pass();
        logic [31:0] rd; int bc;
        lat = 3; ev_q.delete();
        for (int i = 0; i < 2; i++) begin
            access(32'h8000_0010, 1'b0, 32'h0, 4'hF, rd, bc);
            // IDLE decode cycle + 3 mem busy cycles
            checks++; if (bc !== 4) begin errors++; $display("FAIL pass_busy[%0d] got=%0d exp=4", i, bc); end
            checks++; if (rd !== 32'hDA00_0010) begin errors++; $display("FAIL pass_data[%0d] got=%h exp=da000010", i, rd); end
            checks++; if (ev_q.size() !== i + 1) begin errors++; $display("FAIL pass_nreq[%0d] got=%0d exp=%0d", i, ev_q.size(), i + 1); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd; int bc, fd, cd;
        access(32'h500, 1'b1, 32'h0BAD_F00D, 4'hF, rd, bc);
        checks++; if (bc !== 0) begin errors++; $display("FAIL flush_setup_hit got=%0d exp=0", bc); end
        lat = 0; ev_q.delete(); fd = 0; cd = 0;
        flush = 1'b1; @(posedge CLK); #1 flush = 1'b0;
        for (int k = 0; k < 1000 && fd == 0; k++) begin
            @(negedge CLK); fd += int'(flush_done); cd += int'(clear_done);
        end
        repeat (3) begin @(negedge CLK); fd += int'(flush_done); cd += int'(clear_done); end
        @(posedge CLK); #1;
        checks++; if (fd !== 1 || cd !== 0) begin errors++; $display("FAIL flush_done_pulse got=%0d/%0d exp=1/0", fd, cd); end
        checks++; if (ev_q.size() !== 4) begin errors++; $display("FAIL flush_nwr got=%0d exp=4", ev_q.size()); end
        else begin
            checks++; if (ev_q[0] !== {1'b1, 32'h100, 32'h5A00_0100} || ev_q[1] !== {1'b1, 32'h104, 32'h1122_CCDD})
                begin errors++; $display("FAIL flush_wb_way0 got=%h,%h", ev_q[0], ev_q[1]); end
            checks++; if (ev_q[2] !== {1'b1, 32'h500, 32'h0BAD_F00D} || ev_q[3] !== {1'b1, 32'h504, 32'h5A00_0504})
                begin errors++; $display("FAIL flush_wb_way1 got=%h,%h", ev_q[2], ev_q[3]); end
        end
        access(32'h100, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 0 || rd !== 32'h5A00_0100) begin errors++; $display("FAIL flush_keep0 got=%h/%0d exp=5a000100/0", rd, bc); end
        access(32'h500, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 0 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL flush_keep1 got=%h/%0d exp=0badf00d/0", rd, bc); end
    endtask

    task automatic test_flush_clean();
        int k;
        lat = 0; ev_q.delete();
        flush = 1'b1; @(posedge CLK); #1 flush = 1'b0;
        // sampling cycle, then 64*2 scan cycles, done in cycle 129
        for (k = 1; k < 400; k++) begin
            @(negedge CLK);
            if (flush_done) break;
        end
        checks++; if (k !== 129) begin errors++; $display("FAIL flush_clean_latency got=%0d exp=129", k); end
        @(negedge CLK);
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_width got=%b exp=0", flush_done); end
        checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL flush_clean_nwr got=%0d exp=0", ev_q.size()); end
        @(posedge CLK); #1;
    endtask

    task automatic test_clear_flush();
        logic [31:0] rd; int bc, fd, cd;
        access(32'h100, 1'b1, 32'h1234_5678, 4'hF, rd, bc);
        lat = 0; ev_q.delete(); fd = 0; cd = 0;
        clear = 1'b1; flush = 1'b1; @(posedge CLK); #1 begin clear = 1'b0; flush = 1'b0; end
        for (int k = 0; k < 1000 && cd == 0 && fd == 0; k++) begin
            @(negedge CLK); fd += int'(flush_done); cd += int'(clear_done);
        end
        repeat (3) begin @(negedge CLK); fd += int'(flush_done); cd += int'(clear_done); end
        @(posedge CLK); #1;
        checks++; if (cd !== 1 || fd !== 0) begin errors++; $display("FAIL clear_pulse got=clr%0d/fl%0d exp=1/0", cd, fd); end
        checks++; if (ev_q.size() !== 2) begin errors++; $display("FAIL clear_nwr got=%0d exp=2", ev_q.size()); end
        else begin
            checks++; if (ev_q[0] !== {1'b1, 32'h100, 32'h1234_5678} || ev_q[1] !== {1'b1, 32'h104, 32'h1122_CCDD})
                begin errors++; $display("FAIL clear_wb got=%h,%h", ev_q[0], ev_q[1]); end
        end
        lat = 1;
        // model memory does not store writes, so the refill returns the pattern
        access(32'h100, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 5 || rd !== 32'h5A00_0100) begin errors++; $display("FAIL clear_then_miss got=%h/%0d exp=5a000100/5", rd, bc); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int bc;
        lat = 20;
        proc_addr = 32'h500; proc_ren = 1'b1; proc_wen = 1'b0;
        @(negedge CLK); @(negedge CLK);
        checks++; if (mem_ren !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL rstmid_fetch got=%b/%h exp=1/500", mem_ren, mem_addr); end
        #1 nRST = 1'b0;
        #1;
        checks++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL rstmid_drop got=%b%b exp=00", mem_ren, mem_wen); end
        checks++; if (proc_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b exp=1", proc_busy); end
        proc_ren = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        lat = 1;
        access(32'h100, 1'b0, 32'h0, 4'hF, rd, bc);
        checks++; if (bc !== 5) begin errors++; $display("FAIL rstmid_lost got=%0d exp=5", bc); end
    endtask

    task automatic test_protocol();
        checks++; if (both_viol !== 0) begin errors++; $display("FAIL ren_and_wen got=%0d exp=0", both_viol); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_evict();
        test_pass();
        test_flush();
        test_flush_clean();
        test_clear_flush();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
